// File: rtl/decrypt_pkg.sv
// Shared types and constants for the AES-128 decrypt sequencer.
package decrypt_pkg;

  localparam int NUM_ROUNDS = 10;
  localparam int BLOCK_W    = 128;
  localparam int RCON_W     = 4;

  // Counter values in the counter's own width, so compares stay width-exact.
  localparam logic [RCON_W-1:0] LAST_ROUND = RCON_W'(NUM_ROUNDS);
  localparam logic [RCON_W-1:0] CNT_ONE    = RCON_W'(1);
  localparam logic [RCON_W-1:0] CNT_ZERO   = '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_KEYEXP,
    ST_ROUND,
    ST_DONE
  } state_e;

endpackage

// File: rtl/decrypt_key_cache.sv
// Single-entry cache of the last fully expanded cipher key.
// The entry becomes valid only once a full expansion has finished, and
// stays valid until reset.
module decrypt_key_cache
  import decrypt_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               update,
  input  logic [BLOCK_W-1:0] update_key,
  input  logic [BLOCK_W-1:0] lookup_key,
  output logic               hit
);

  logic               valid_q, valid_d;
  logic [BLOCK_W-1:0] key_q, key_d;

  // Next-state: overwrite the single entry when an expansion completes.
  always_comb begin
    valid_d = valid_q;
    key_d   = key_q;
    if (update) begin
      valid_d = 1'b1;
      key_d   = update_key;
    end
  end

  // Cache registers; reset invalidates the entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      key_q   <= '0;
    end else begin
      valid_q <= valid_d;
      key_q   <= key_d;
    end
  end

  assign hit = valid_q && (lookup_key == key_q);

endmodule

// File: rtl/decrypt_sequencer.sv
// Control sequencer for an iterative AES-128 decryptor. It drives an
// external round datapath and key-schedule unit: forward key expansion
// (skipped when the key is cached), then 11 inverse steps from round 10
// down to round 0, then holds the plaintext until the consumer takes it.
module decrypt_sequencer
  import decrypt_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] ciphertext,
  input  logic [BLOCK_W-1:0] key,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] plaintext,
  output logic               dp_load,
  output logic [RCON_W-1:0]  dp_round,
  output logic               dp_first,
  output logic               dp_last,
  input  logic [BLOCK_W-1:0] dp_result,
  output logic               ks_load,
  output logic               ks_fwd,
  output logic               ks_inv,
  output logic [RCON_W-1:0]  ks_rcon,
  output logic               busy,
  output logic               cache_hit
);

  state_e             state_q, state_d;
  logic [RCON_W-1:0]  cnt_q, cnt_d;
  logic               armed_q, armed_d;
  logic [BLOCK_W-1:0] key_q, key_d;
  logic [BLOCK_W-1:0] block_q, block_d;
  logic               cache_update;
  logic               key_hit;

  decrypt_key_cache u_key_cache (
    .clk        (clk),
    .rst        (rst),
    .update     (cache_update),
    .update_key (key_q),
    .lookup_key (key),
    .hit        (key_hit)
  );

  // Next-state and output decode. One counter serves as rcon index during
  // expansion (counting up) and as round index during decryption (down);
  // both directions stop at their end value instead of wrapping.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    key_d        = key_q;
    block_d      = block_q;
    armed_d      = 1'b1;
    cache_update = 1'b0;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    dp_load      = 1'b0;
    dp_round     = '0;
    dp_first     = 1'b0;
    dp_last      = 1'b0;
    ks_load      = 1'b0;
    ks_fwd       = 1'b0;
    ks_inv       = 1'b0;
    ks_rcon      = '0;
    busy         = 1'b0;
    cache_hit    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // armed_q keeps in_ready low until the first edge after reset.
        in_ready = armed_q;
        if (in_valid && armed_q) begin
          dp_load = 1'b1;
          key_d   = key;
          block_d = ciphertext;
          if (key_hit) begin
            cache_hit = 1'b1;
            state_d   = ST_ROUND;
            cnt_d     = LAST_ROUND;
          end else begin
            ks_load = 1'b1;
            state_d = ST_KEYEXP;
            cnt_d   = CNT_ONE;
          end
        end
      end

      ST_KEYEXP: begin
        busy    = 1'b1;
        ks_fwd  = 1'b1;
        ks_rcon = cnt_q;
        if (cnt_q >= LAST_ROUND) begin
          // Expansion complete: only now is the key worth remembering.
          cache_update = 1'b1;
          state_d      = ST_ROUND;
          cnt_d        = LAST_ROUND;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_ROUND: begin
        busy     = 1'b1;
        dp_round = cnt_q;
        ks_rcon  = cnt_q;
        dp_first = (cnt_q == LAST_ROUND);
        dp_last  = (cnt_q == CNT_ZERO);
        ks_inv   = (cnt_q != CNT_ZERO);
        if (cnt_q == CNT_ZERO) begin
          // dp_result already reflects the final step during this cycle.
          block_d = dp_result;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase

    // The block register holds the ciphertext while in flight; only the
    // finished plaintext is ever shown on the output.
    plaintext = (state_q == ST_DONE) ? block_q : '0;
  end

  // State, counter and block registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      armed_q <= 1'b0;
      key_q   <= '0;
      block_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      key_q   <= key_d;
      block_q <= block_d;
    end
  end

endmodule

// File: tb/tb_decrypt_sequencer.sv
// Scoreboard bench for decrypt_sequencer with a behavioural AES-128
// datapath/key-schedule model driven by the sequencer's control outputs.
module tb_decrypt_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] ciphertext;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] plaintext;
  logic         dp_load;
  logic [3:0]   dp_round;
  logic         dp_first;
  logic         dp_last;
  logic [127:0] dp_result;
  logic         ks_load;
  logic         ks_fwd;
  logic         ks_inv;
  logic [3:0]   ks_rcon;
  logic         busy;
  logic         cache_hit;

  decrypt_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ciphertext(ciphertext), .key(key), .out_valid(out_valid),
    .out_ready(out_ready), .plaintext(plaintext), .dp_load(dp_load),
    .dp_round(dp_round), .dp_first(dp_first), .dp_last(dp_last),
    .dp_result(dp_result), .ks_load(ks_load), .ks_fwd(ks_fwd),
    .ks_inv(ks_inv), .ks_rcon(ks_rcon), .busy(busy), .cache_hit(cache_hit)
  );

  always #5 clk = ~clk;

  // ---------------- AES primitives ----------------
  logic [7:0] sbox [256];
  logic [7:0] inv_sbox [256];

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xt(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl1(input logic [7:0] b);
    return {b[6:0], b[7]};
  endfunction

  function automatic void init_sbox();
    logic [7:0] inv, s, r;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0) begin
        for (int y = 1; y < 256; y++) begin
          if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
        end
      end
      s = inv; r = inv;
      for (int k = 0; k < 4; k++) begin
        r = rotl1(r);
        s = s ^ r;
      end
      s = s ^ 8'h63;
      sbox[x] = s;
      inv_sbox[s] = 8'(x);
    end
  endfunction

  function automatic logic [127:0] inv_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = inv_sbox[s[127-8*i -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];    a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];    a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gm(a0,8'd14) ^ gm(a1,8'd11) ^ gm(a2,8'd13) ^ gm(a3,8'd9);
      o[119-32*c -: 8] = gm(a0,8'd9)  ^ gm(a1,8'd14) ^ gm(a2,8'd11) ^ gm(a3,8'd13);
      o[111-32*c -: 8] = gm(a0,8'd13) ^ gm(a1,8'd9)  ^ gm(a2,8'd14) ^ gm(a3,8'd11);
      o[103-32*c -: 8] = gm(a0,8'd11) ^ gm(a1,8'd13) ^ gm(a2,8'd9)  ^ gm(a3,8'd14);
    end
    return o;
  endfunction

  function automatic logic [7:0] rcon_of(input int i);
    logic [7:0] r;
    r = 8'h01;
    for (int k = 1; k < i; k++) r = xt(r);
    return r;
  endfunction

  function automatic logic [127:0] key_step(input logic [127:0] p, input logic [7:0] rc);
    logic [31:0] t, w0, w1, w2, w3;
    t = {p[23:0], p[31:24]};
    t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
    w0 = p[127:96] ^ t;
    w1 = p[95:64] ^ w0;
    w2 = p[63:32] ^ w1;
    w3 = p[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Straight-line AES-128 decryption used for scoreboard expectations.
  function automatic logic [127:0] aes_decrypt(input logic [127:0] ct, input logic [127:0] k);
    logic [127:0] ks [0:10];
    logic [127:0] s;
    ks[0] = k;
    for (int i = 1; i <= 10; i++) ks[i] = key_step(ks[i-1], rcon_of(i));
    s = ct ^ ks[10];
    for (int r = 9; r >= 1; r--) s = inv_mix(inv_sub(inv_shift(s)) ^ ks[r]);
    return inv_sub(inv_shift(s)) ^ ks[0];
  endfunction

  // ---------------- datapath / key-schedule model ----------------
  logic [127:0] dp_state;
  logic [127:0] rk [0:10];
  logic         sn_load, sn_ksl, sn_fwd, sn_first, sn_mid;
  logic [3:0]   sn_rcon, sn_round;
  logic [127:0] sn_ct, sn_key;

  initial begin
    forever begin
      @(negedge clk);
      sn_load  = dp_load;   sn_ct  = ciphertext;
      sn_ksl   = ks_load;   sn_key = key;
      sn_fwd   = ks_fwd;    sn_rcon = ks_rcon;
      sn_first = dp_first;  sn_round = dp_round;
      sn_mid   = busy && !ks_fwd && !dp_first && !dp_last;
    end
  end

  always @(posedge clk) begin
    if (sn_load) dp_state <= sn_ct;
    else if (sn_first) dp_state <= dp_state ^ rk[10];
    else if (sn_mid) dp_state <= inv_mix(inv_sub(inv_shift(dp_state)) ^ rk[sn_round]);
    if (sn_ksl) rk[0] <= sn_key;
    else if (sn_fwd && int'(sn_rcon) >= 1 && int'(sn_rcon) <= 10)
      rk[sn_rcon] <= key_step(rk[int'(sn_rcon) - 1], rcon_of(int'(sn_rcon)));
  end

  always_comb begin
    dp_result = dp_state;
    if (dp_last) dp_result = inv_sub(inv_shift(dp_state)) ^ rk[0];
  end

  // ---------------- scoreboard and checking ----------------
  typedef struct {
    logic [127:0] pt;
    int           lat;
    bit           hit;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  bit           ref_valid = 1'b0;
  logic [127:0] ref_key = '0;

  bit           active = 1'b0, seen_valid = 1'b0, hit_obs = 1'b0;
  int           acc_cyc = 0, first_valid_cyc = 0, hs_cyc = 0, txn = 0;
  int           n_fwd = 0, n_inv = 0, n_first = 0, n_last = 0;
  int           trace_bad = 0, unstable = 0, exp_round = 10, exp_rcon = 1;
  int           excl_bad = 0, rst_valid_bad = 0;
  logic [127:0] held_pt = '0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if ((ks_fwd && (ks_inv || dp_load || dp_first || dp_last)) ||
          (dp_load && (ks_inv || dp_first || dp_last)) || (dp_first && dp_last))
        excl_bad++;
      if (!rst) begin
        if (out_valid) rst_valid_bad++;
        active = 1'b0;
        seen_valid = 1'b0;
      end else if (in_valid && in_ready) begin
        active = 1'b1; seen_valid = 1'b0; acc_cyc = cyc; hit_obs = cache_hit;
        n_fwd = 0; n_inv = 0; n_first = 0; n_last = 0;
        trace_bad = 0; unstable = 0; exp_round = 10; exp_rcon = 1;
        if (!dp_load || (ks_load == cache_hit)) trace_bad++;
      end else if (active) begin
        if (ks_fwd) begin
          n_fwd++;
          if (int'(ks_rcon) != exp_rcon) trace_bad++;
          if (exp_rcon < 10) exp_rcon++;
        end
        if (busy && !ks_fwd) begin
          if (int'(dp_round) != exp_round || ks_rcon != dp_round) trace_bad++;
          if (exp_round > 0) exp_round--;
        end
        if (ks_inv) n_inv++;
        if (dp_first) n_first++;
        if (dp_last) n_last++;
        if (out_valid) begin
          if (!seen_valid) begin
            seen_valid = 1'b1; first_valid_cyc = cyc; held_pt = plaintext;
          end else if (plaintext !== held_pt) unstable++;
        end
        if (out_valid && out_ready) begin
          hs_cyc = cyc;
          active = 1'b0;
          if (exp_q.size() == 0) begin
            chk("out_valid_without_request", out_valid, 1'b0);
          end else begin
            e = exp_q.pop_front();
            txn++;
            $display("txn %0d pt=%h lat=%0d hit=%0b fwd=%0d inv=%0d", txn, plaintext,
                     first_valid_cyc - acc_cyc, hit_obs, n_fwd, n_inv);
            chk("plaintext", plaintext, e.pt);
            chk("latency", first_valid_cyc - acc_cyc, e.lat);
            chk("cache_hit", hit_obs, e.hit);
            chk("ks_fwd_cycles", n_fwd, e.hit ? 0 : 10);
            chk("ks_inv_cycles", n_inv, 10);
            chk("dp_first_count", n_first, 1);
            chk("dp_last_count", n_last, 1);
            chk("control_trace", trace_bad, 0);
            chk("plaintext_stable", unstable, 0);
          end
        end
      end else if (out_valid && out_ready) begin
        chk("out_valid_while_idle", out_valid, 1'b0);
      end
    end
  end

  // ---------------- stimulus ----------------
  bit rand_rdy = 1'b0;
  bit rdy_cmd = 1'b1;
  always @(posedge clk) begin
    #2;
    out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_cmd;
  end

  function automatic logic [18:0] ctl_vec();
    return {in_ready, out_valid, busy, cache_hit, dp_load, dp_first, dp_last,
            ks_load, ks_fwd, ks_inv, dp_round, ks_rcon, |plaintext};
  endfunction

  task automatic start(input logic [127:0] k, input logic [127:0] ct);
    key = k;
    ciphertext = ct;
    in_valid = 1'b1;
  endtask

  task automatic wait_accept(input bit check_gap, input logic [127:0] exp_pt);
    exp_t e;
    bit got;
    got = 1'b0;
    for (int i = 0; i < 120 && !got; i++) begin
      @(negedge clk);
      if (in_valid && in_ready) got = 1'b1;
    end
    if (!got) begin
      chk("accept_timeout", in_ready, 1'b1);
    end else begin
      e.hit = ref_valid && (key == ref_key);
      e.lat = e.hit ? 12 : 22;
      e.pt  = exp_pt;
      exp_q.push_back(e);
      ref_valid = 1'b1;
      ref_key = key;
      if (check_gap) chk("accept_gap_after_handshake", cyc - hs_cyc, 1);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send(input logic [127:0] k, input logic [127:0] ct, input logic [127:0] pt);
    start(k, ct);
    wait_accept(1'b0, pt);
  endtask

  task automatic drain();
    int i;
    i = 0;
    while ((exp_q.size() != 0 || active) && i < 300) begin
      @(negedge clk);
      i++;
    end
    if (i >= 300) chk("drain_timeout", exp_q.size(), 0);
  endtask

  localparam logic [127:0] K1 = 128'h6772696666696e746772696666696e74;
  localparam logic [127:0] C1 = 128'h27a15792bba1cb6cba23475fdaa1cb1a;
  localparam logic [127:0] P1 = 128'h636f6d7061726368636f6d7061726368;
  localparam logic [127:0] K2 = 128'h0f1571c947d9e8590cb7add6af7f6798;
  localparam logic [127:0] C2 = 128'hff0b844a0853bf7c6934ab4364148fb9;
  localparam logic [127:0] P2 = 128'h0123456789abcdeffedcba9876543210;

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    logic [127:0] pool [3];
    logic [127:0] k, ct;
    bit found;
    init_sbox();
    rst = 1'b0;
    in_valid = 1'b0;
    key = '0;
    ciphertext = '0;
    #1 chk("reset_outputs_zero", ctl_vec(), '0);
    #11 rst = 1'b1;
    #1 chk("in_ready_before_first_edge", in_ready, 1'b0);
    @(posedge clk);
    #1 chk("in_ready_after_first_edge", in_ready, 1'b1);

    // Cold miss, then hit with the same key, then a new key.
    send(K1, C1, P1); drain();
    send(K1, C1, P1); drain();
    send(K2, C2, P2); drain();

    // Backpressure: result held in DONE while the next request waits.
    rdy_cmd = 1'b0;
    send(K2, C2, P2);
    start(K1, C1);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (out_valid) found = 1'b1;
    end
    if (!found) chk("backpressure_out_valid_timeout", out_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("in_ready_low_in_done", in_ready, 1'b0);
    end
    @(posedge clk);
    #1 rdy_cmd = 1'b1;
    wait_accept(1'b1, P1);
    drain();

    // Asynchronous reset in the middle of the inverse rounds.
    send(K2, C2, P2);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (busy && !ks_fwd && dp_round == 4'd5) found = 1'b1;
    end
    if (!found) chk("round5_timeout", dp_round, 4'd5);
    #2 rst = 1'b0;
    exp_q.delete();
    ref_valid = 1'b0;
    #1 chk("midround_reset_outputs_zero", ctl_vec(), '0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("in_ready_after_midround_release", in_ready, 1'b0);
    @(posedge clk);
    #1 chk("in_ready_rearmed", in_ready, 1'b1);
    send(K2, C2, P2); drain();

    // Randomised traffic with random consumer backpressure.
    pool[0] = K1;
    pool[1] = {$urandom, $urandom, $urandom, $urandom};
    pool[2] = {$urandom, $urandom, $urandom, $urandom};
    rand_rdy = 1'b1;
    for (int n = 0; n < 16; n++) begin
      k  = pool[$urandom_range(0, 2)];
      ct = {$urandom, $urandom, $urandom, $urandom};
      send(k, ct, aes_decrypt(ct, k));
    end
    drain();
    rand_rdy = 1'b0;
    repeat (3) @(negedge clk);

    chk("control_exclusivity_violations", excl_bad, 0);
    chk("out_valid_during_reset", rst_valid_bad, 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
